// File: rtl/serproc_pkg.sv
// Shared types for the parametrised serial logic processor: function codes,
// router selects and controller states.
package serproc_pkg;

  typedef enum logic [2:0] {
    F_AND  = 3'b000,
    F_OR   = 3'b001,
    F_XOR  = 3'b010,
    F_ONE  = 3'b011,
    F_NAND = 3'b100,
    F_NOR  = 3'b101,
    F_XNOR = 3'b110,
    F_ZERO = 3'b111
  } func_e;

  typedef enum logic [1:0] {
    KEEP = 2'b00,
    TO_B = 2'b01,
    TO_A = 2'b10,
    SWAP = 2'b11
  } route_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_logic_processor_n_alu.sv
// One-bit function unit and router: computes f from the current LSBs and
// chooses the new MSBs shifted into A and B.
module serial_bit_alu
  import serproc_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [2:0] F_q,
  input  logic [1:0] R_q,
  output logic       newA,
  output logic       newB
);

  logic f;

  always_comb begin
    f = 1'b0;
    case (func_e'(F_q))
      F_AND:  f = a & b;
      F_OR:   f = a | b;
      F_XOR:  f = a ^ b;
      F_ONE:  f = 1'b1;
      F_NAND: f = ~(a & b);
      F_NOR:  f = ~(a | b);
      F_XNOR: f = ~(a ^ b);
      F_ZERO: f = 1'b0;
    endcase

    newA = a;
    newB = b;
    case (route_e'(R_q))
      KEEP: ;
      TO_B: newB = f;
      TO_A: newA = f;
      SWAP: begin
        newA = b;
        newB = a;
      end
    endcase
  end

endmodule

// File: rtl/serial_logic_processor_n.sv
// WIDTH-bit serial logic processor: loads A/B, then streams them LSB-first
// through serial_bit_alu for WIDTH cycles with a Busy/Done handshake.
// Optional Zero flag output enabled by defining SERPROC_ZFLAG_EN.
module serial_logic_processor_n
  import serproc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadA,
  input  logic             LoadB,
  input  logic             Execute,
  input  logic [WIDTH-1:0] Din,
  input  logic [2:0]       F,
  input  logic [1:0]       R,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done
`ifdef SERPROC_ZFLAG_EN
  ,
  output logic             Zero
`endif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       f_q, f_d;
  logic [1:0]       r_q, r_d;
  logic             done_q, done_d;
  logic             new_a, new_b;

  serial_bit_alu u_alu (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .F_q  (f_q),
    .R_q  (r_q),
    .newA (new_a),
    .newB (new_b)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    r_d     = r_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (LoadA) a_d = Din;
        if (LoadB) b_d = Din;
        if (!LoadA && !LoadB && Execute) begin
          f_d     = F;
          r_d     = R;
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_d = {new_a, a_q[WIDTH-1:1]};
        b_d = {new_b, b_q[WIDTH-1:1]};
        // done_q marks the first HOLD cycle; it is set on the last shift edge
        if (cnt_q == '0) begin
          state_d = HOLD;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (!Execute) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      f_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

  assign A    = a_q;
  assign B    = b_q;
  assign Busy = (state_q == SHIFT);
  assign Done = done_q;

`ifdef SERPROC_ZFLAG_EN
  logic zero_q;

  always_ff @(posedge Clk) begin
    if (Reset)       zero_q <= 1'b0;
    else if (done_q) zero_q <= (a_q == '0) && (b_q == '0);
  end

  assign Zero = zero_q;
`endif

endmodule

// File: doc/serial_logic_processor_n.md
Name: serial_logic_processor_n

Overview:
- Parametrised successor to the 8-bit serial logic processor.
- Holds two WIDTH-bit registers A and B, loaded from Din.
- On Execute, streams both registers LSB-first through a 1-bit function unit and router for exactly WIDTH cycles.
- Adds a counted FSM with Busy/Done handshake, F/R latched at start, one-operation-per-press rule, and an optional zero flag.
- Sits behind the board-level button/switch synchronizers and drives the hex displays and LEDs.

Parameters:
- WIDTH, 8, register width and number of shift cycles per operation (legal range 2..32).
- CNT_W, $clog2(WIDTH), width of the shift counter (derived; do not override).

Ports:
- Clk  input  1  system clock, all logic on rising edge.
- Reset  input  1  synchronous, active-high; clears all state.
- LoadA  input  1  synchronized active-high level; A <= Din.
- LoadB  input  1  synchronized active-high level; B <= Din.
- Execute  input  1  synchronized active-high level; start an operation.
- Din  input  WIDTH  parallel load data.
- F  input  3  function select.
- R  input  2  routing select.
- A  output  WIDTH  register A contents.
- B  output  WIDTH  register B contents.
- Busy  output  1  high during every SHIFT cycle.
- Done  output  1  one-cycle pulse on completion.

Behaviour:
- Interface: one clock, Clk; reset is synchronous and active-high, port Reset. Reset takes priority over everything, including mid-operation.
- Reset values: A=0, B=0, Busy=0, Done=0, counter=0, state=IDLE.
- FSM states: IDLE, SHIFT, HOLD.
- IDLE:
  - LoadA loads A <= Din; LoadB loads B <= Din. Both asserted: both load.
  - Any load asserted: Execute is ignored that cycle.
  - Otherwise Execute=1: latch F_q <= F and R_q <= R, counter <= WIDTH-1, go to SHIFT.
- SHIFT:
  - Busy=1. Each cycle, A and B shift right by one. New MSBs come from the router.
  - LoadA, LoadB, and changes to F, R, Din are ignored.
  - When counter==0, go to HOLD; otherwise decrement the counter.
- HOLD:
  - Done=1 on the first HOLD cycle only.
  - Remain in HOLD while Execute=1; go to IDLE when Execute=0.
  - Loads are ignored in HOLD.
- Latency: Execute sampled at edge k gives Busy during cycles k+1..k+WIDTH. Final A/B are valid from edge k+WIDTH onward. Done is high in cycle k+WIDTH+1.
- Function on the current LSBs a and b (f is the 1-bit result):
  - F=000 AND, 001 OR, 010 XOR, 011 constant 1.
  - F=100 NAND, 101 NOR, 110 XNOR, 111 constant 0.
- Routing (new A MSB, new B MSB):
  - R=00: (a, b).
  - R=01: (a, f).
  - R=10: (f, b).
  - R=11: (b, a), i.e. swap.
- After WIDTH shifts the result is the bitwise operation on the full registers. No arithmetic, carries or width growth.

Optional Feature:
- Macro SERPROC_ZFLAG_EN.
- Defined: adds output port Zero (1 bit). Zero is registered and updated only on the Done cycle to (A_final==0 && B_final==0). It holds its value until the next Done or Reset; reset value 0.
- Undefined: no Zero port, no extra logic. All other behaviour is identical.

Decomposition:
- Package serproc_pkg holds:
  - func_e (3-bit enum for the eight functions);
  - route_e (2-bit enum: KEEP, TO_B, TO_A, SWAP);
  - state_e (IDLE, SHIFT, HOLD).
- One combinational sub-module, serial_bit_alu: inputs a, b, F_q, R_q; outputs newA, newB. It merges the compute and router stages.
- The FSM, counter and registers stay in the top module.

Test Plan:
- WIDTH=8, A=0x33, B=0x55, F=010, R=10, Execute one cycle -> Busy for 8 cycles; Done in cycle 9; A=0x66, B=0x55.
- Same loads, F=000, R=11 -> A=0x55, B=0x33 (swap; F ignored); Done pulses exactly once.
- Execute held high for 30 cycles with F=001, R=01 -> only one operation runs; B = A|B once; no second Busy until Execute falls and rises again.
- Mid-operation: Reset at the 3rd SHIFT cycle -> next cycle A=0, B=0, Busy=0, state IDLE. LoadA asserted during SHIFT -> A is unaffected by Din.
- WIDTH=16, A=0x00FF, B=0x0F0F, F=000, R=01 -> 16 Busy cycles; B=0x000F; A=0x00FF.
- With SERPROC_ZFLAG_EN defined: A=0xF0, B=0x0F, F=111, R=10 -> A=0x00. Zero stays 0 because B≠0. Repeating with R=11 swaps the registers (A=0x0F, B=0x00) and Zero stays 0 because A≠0.
